// File: rtl/bus_uart65.sv
// bus_uart65: 6502-bus UART responder. Four byte registers (DATA, STATUS,
// CTRL, DIV), 8N1 framing at 16x oversampling, registered active-low IRQ.
//
// TX states:
//   state    | meaning
//   TX_IDLE  | line high, waiting for THR to be filled (TDRE=0)
//   TX_START | driving the start bit (low) for 16 ticks
//   TX_DATA  | shifting 8 data bits LSB first, 16 ticks each
//   TX_STOP  | driving the stop bit (high) for 16 ticks
//
// RX states:
//   state    | meaning
//   RX_IDLE  | waiting for a synchronised 1->0 edge on rxd
//   RX_START | qualifying the start bit at its mid point
//   RX_DATA  | sampling 8 data bits LSB first, one per 16 ticks
//   RX_STOP  | sampling the stop bit, then storing the byte

module bus_uart65 #(
    parameter logic [7:0] DIV_RESET  = 8'd12,
    parameter int         OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       cs,
    input  logic [1:0] A,
    input  logic       RWn,
    input  logic       strobe,
    input  logic [7:0] D_i,
    output logic [7:0] D_o,
    output logic       D_oe,
    output logic       IRQn,
    output logic       txd,
    input  logic       rxd
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // bus decode
    logic wr_en, rd_en;
    logic wr_data, wr_status, wr_ctrl, wr_div, rd_data;

    assign wr_en     = cs & ~RWn & strobe;
    assign rd_en     = cs &  RWn & strobe;
    assign wr_data   = wr_en & (A == 2'd0);
    assign wr_status = wr_en & (A == 2'd1);
    assign wr_ctrl   = wr_en & (A == 2'd2);
    assign wr_div    = wr_en & (A == 2'd3);
    assign rd_data   = rd_en & (A == 2'd0);

    // configuration registers
    logic       txie, rxie;
    logic [7:0] div_reg;

    // baud generator
    logic [7:0] baud_cnt;
    logic       tick;

    // transmitter
    tx_state_t  tx_state;
    logic [7:0] thr;
    logic [7:0] tx_shift;
    logic       tdre;
    logic [3:0] tx_ticks;
    logic [2:0] tx_bit;

    // receiver
    rx_state_t  rx_state;
    logic       rx_sync1, rx_sync2, rx_prev;
    logic [7:0] rx_shift;
    logic [7:0] rdr;
    logic       rdrf, ovr, fe;
    logic [3:0] rx_ticks;
    logic [2:0] rx_bit;

    logic [7:0] status;

    // CTRL and DIV register writes
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            txie    <= 1'b0;
            rxie    <= 1'b0;
            div_reg <= DIV_RESET;
        end else begin
            if (wr_ctrl) begin
                txie <= D_i[1];
                rxie <= D_i[0];
            end
            if (wr_div) begin
                div_reg <= D_i;
            end
        end
    end

    // baud down-counter; a DIV change is only picked up at the next reload
    assign tick = (baud_cnt == 8'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            baud_cnt <= DIV_RESET;
        end else if (tick) begin
            baud_cnt <= div_reg;
        end else begin
            baud_cnt <= baud_cnt - 8'd1;
        end
    end

    // transmit FSM plus THR/TDRE holding register
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            thr      <= 8'h00;
            tx_shift <= 8'h00;
            tdre     <= 1'b1;
            tx_ticks <= 4'd0;
            tx_bit   <= 3'd0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    txd <= 1'b1;
                    if (!tdre) begin
                        tx_shift <= thr;
                        tdre     <= 1'b1;
                        tx_ticks <= 4'd0;
                        txd      <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (tx_ticks == LAST_TICK) begin
                            tx_ticks <= 4'd0;
                            tx_bit   <= 3'd0;
                            txd      <= tx_shift[0];
                            tx_state <= TX_DATA;
                        end else begin
                            tx_ticks <= tx_ticks + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_ticks == LAST_TICK) begin
                            tx_ticks <= 4'd0;
                            if (tx_bit == 3'd7) begin
                                txd      <= 1'b1;
                                tx_state <= TX_STOP;
                            end else begin
                                tx_bit   <= tx_bit + 3'd1;
                                tx_shift <= {1'b0, tx_shift[7:1]};
                                txd      <= tx_shift[1];
                            end
                        end else begin
                            tx_ticks <= tx_ticks + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_ticks == LAST_TICK) begin
                            tx_ticks <= 4'd0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_ticks <= tx_ticks + 4'd1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
            // a CPU write beats the load-clock TDRE set so a freshly queued byte is never dropped
            if (wr_data) begin
                thr  <= D_i;
                tdre <= 1'b0;
            end
        end
    end

    // two-flop synchroniser on rxd plus one delayed copy for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= rxd;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    // receive FSM plus RDR and the RDRF/OVR/FE status flags
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_shift <= 8'h00;
            rdr      <= 8'h00;
            rdrf     <= 1'b0;
            ovr      <= 1'b0;
            fe       <= 1'b0;
            rx_ticks <= 4'd0;
            rx_bit   <= 3'd0;
        end else begin
            if (rd_data) begin
                rdrf <= 1'b0;
                ovr  <= 1'b0;
            end
            if (wr_status) begin
                ovr <= 1'b0;
                fe  <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync2) begin
                        rx_ticks <= 4'd0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_ticks == MID_TICK) begin
                            rx_ticks <= 4'd0;
                            rx_bit   <= 3'd0;
                            rx_state <= rx_sync2 ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_ticks == LAST_TICK) begin
                            rx_ticks <= 4'd0;
                            rx_shift <= {rx_sync2, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) begin
                                rx_state <= RX_STOP;
                            end
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_ticks == LAST_TICK) begin
                            rx_ticks <= 4'd0;
                            rx_state <= RX_IDLE;
                            if (!rx_sync2) begin
                                fe <= 1'b1;
                            end
                            // a DATA read in this same clock has already consumed the old byte
                            if (!rdrf || rd_data) begin
                                rdr  <= rx_shift;
                                rdrf <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end else begin
                            rx_ticks <= rx_ticks + 4'd1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // registered interrupt request
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            IRQn <= 1'b1;
        end else begin
            IRQn <= ~((rdrf & rxie) | (tdre & txie));
        end
    end

    assign status = {~IRQn, 2'b00, tdre, rdrf, ovr, fe, 1'b0};
    assign D_oe   = cs & RWn;

    // read data mux, zero whenever the bus is not being read
    always_comb begin
        D_o = 8'h00;
        if (cs && RWn) begin
            case (A)
                2'd0:    D_o = rdr;
                2'd1:    D_o = status;
                2'd2:    D_o = {6'b000000, txie, rxie};
                default: D_o = div_reg;
            endcase
        end
    end

endmodule
